serial_to_parallel_rx: RTL and testbench
========================================

# serial_to_parallel_rx

Receive-side counterpart of the parallel-to-serial transmitter. Sits downstream of the PAD's `data_out` and samples the serial line one bit per `Clock`. On request it waits for a start bit (logic 0) and shifts in a fixed-width frame MSB-first, start bit included. It then presents the frame as a parallel word with a one-cycle completion strobe, or reports a timeout if no start bit arrives.

## Interface
- `WIDTH`, 48: frame length in bits, start bit included as bit `WIDTH-1`; legal range 2..64.
- `TIMEOUT`, 64: maximum number of enabled idle samples (serial = 1) tolerated while waiting for the start bit; ≥ 1.
- `Clock`  in  1  sole clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-low reset, sampled on `Clock` rising edge.
- `Enable`  in  1  clock-qualifier; when 0, all internal state is frozen.
- `receive`  in  1  request to start a reception; sampled only in IDLE.
- `serial`  in  1  serial data from the pad, MSB first.
- `parallel`  out  WIDTH  last completed frame; registered.
- `complete`  out  1  one-cycle strobe; `parallel` holds the new frame in the same cycle.
- `busy`  out  1  high in WAIT_START, SHIFT and DONE.
- `timeout`  out  1  one-cycle strobe when the start-bit wait expires.

## Operation
- The internal shift register is separate from the `parallel` output register. `parallel` changes only on frame completion.
- Bit counter width is `$clog2(WIDTH+1)`. Idle counter width is `$clog2(TIMEOUT+1)`.
- Every transition and every counter update below requires `Enable` = 1, except reset.
- States:
  - IDLE: `busy`=0. If `receive`=1, go to WAIT_START and clear the bit and idle counters.
  - WAIT_START:
    - If `serial`=0, shift the 0 into the LSB, set bit count to 1, and go to SHIFT.
    - Otherwise increment the idle count. When that increment makes it equal `TIMEOUT`, go to TIMED_OUT.
  - SHIFT: shift register ← {shift[WIDTH-2:0], `serial`}, bit count +1. When the count reaches `WIDTH`, go to DONE and load `parallel` from the completed shift value in the same edge.
  - DONE: `complete`=1 for exactly this cycle. Next state is IDLE unconditionally, even if `Enable`=0.
  - TIMED_OUT: `timeout`=1 for exactly this cycle. Next state is IDLE unconditionally. `parallel` is unchanged.
- `receive` is ignored in every state except IDLE. It is level-sampled, so holding it high in IDLE re-arms immediately after DONE or TIMED_OUT.
- `Enable`=0 mid-frame: no sample is taken, counters hold, and no bit is lost or duplicated.
- Reset (`Reset`=0 at an edge):
  - State ← IDLE; `parallel` ← 0; `complete`, `busy`, `timeout` ← 0; shift register and counters ← 0.
  - Applies from any state, including mid-frame. A partial frame is discarded and produces no `complete`.
- Reset has priority over `Enable` and `receive`.

## Timing
- Reset values: `parallel`=0, `complete`=0, `busy`=0, `timeout`=0.
- `busy` rises in the cycle after `receive` is accepted in IDLE.
- Start bit sampled at edge N. Remaining `WIDTH-1` bits sampled at edges N+1 … N+WIDTH-1 (continuous `Enable`).
- At edge N+WIDTH-1, `parallel` is updated and `complete`=1 for the following cycle. `busy` falls one cycle later.
- Each `Enable`=0 cycle during WAIT_START or SHIFT delays completion by exactly one cycle.
- Timeout: after `TIMEOUT` consecutive enabled samples of 1 in WAIT_START, `timeout`=1 in the next cycle, then IDLE.
- A 0 on the `TIMEOUT`-th sample is a start bit, not a timeout.
- `complete` and `timeout` are never high together.

## Test plan
- Reset: hold `Reset`=0 for 2 cycles with `serial`=0 and `receive`=1 → `parallel`=0, `complete`=0, `busy`=0, `timeout`=0; no state change.
- Nominal (WIDTH=48):
  - Stimulus: pulse `receive`, drive 3 idle 1s, then 48'h3F0F_0F0F_0F01 MSB-first.
  - Response: `complete` high exactly one cycle, 48 cycles after the start-bit edge; `parallel`=48'h3F0F_0F0F_0F01; `busy` low the next cycle.
- Timeout:
  - Stimulus: pulse `receive`, keep `serial`=1 for 64 enabled cycles.
  - Response: `timeout` high one cycle immediately after the 64th sample; `parallel` retains the previous frame; no `complete`.
- Enable gap: drop `Enable` for 5 cycles after bit 20 of the nominal frame → identical `parallel` value; `complete` 5 cycles later than nominal.
- Reset mid-frame:
  - Stimulus: assert `Reset`=0 after 20 bits.
  - Response: `busy`=0 and `parallel`=0 next cycle; no `complete`. A subsequent full frame 48'h0000_0000_0001 is captured correctly.
- Request rules and loopback:
  - `receive` pulsed mid-frame is ignored (single `complete`).
  - Back-to-back frames with `receive` held high: both captured, with exactly one IDLE cycle between `complete` and the next WAIT_START.
  - Loopback from the parallel-to-serial transmitter through the PAD reproduces the transmitted word.

Source files
------------

// File: rtl/serial_to_parallel_rx.sv
// Serial frame receiver: waits for a start bit (0), then shifts in a WIDTH-bit frame MSB-first.
// Presents the frame on a registered parallel port with a one-cycle complete strobe, or flags a timeout.
module serial_to_parallel_rx #(
    parameter int WIDTH   = 48,
    parameter int TIMEOUT = 64
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             receive,
    input  logic             serial,
    output logic [WIDTH-1:0] parallel,
    output logic             complete,
    output logic             busy,
    output logic             timeout
);

    // state      | meaning
    // IDLE       | waiting for a receive request
    // WAIT_START | sampling the line for a start bit, counting idle samples
    // SHIFT      | shifting in the remaining frame bits
    // DONE       | frame presented on parallel, complete strobe
    // TIMED_OUT  | no start bit within TIMEOUT samples, timeout strobe
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        SHIFT      = 3'd2,
        DONE       = 3'd3,
        TIMED_OUT  = 3'd4
    } state_t;

    localparam int BIT_W  = $clog2(WIDTH + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [BIT_W-1:0]  FRAME_BITS = BIT_W'(WIDTH);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);

    state_t state, state_next;

    // The oldest bit only ever lands in parallel, so the shift register keeps WIDTH-1 bits.
    logic [WIDTH-2:0]  shift_reg, shift_next;
    logic [WIDTH-1:0]  shift_full;
    logic [WIDTH-1:0]  parallel_next;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_next, bit_cnt_inc;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_next, idle_cnt_inc;

    assign shift_full   = {shift_reg, serial};
    assign bit_cnt_inc  = bit_cnt + 1'b1;
    assign idle_cnt_inc = idle_cnt + 1'b1;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            parallel  <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            idle_cnt  <= idle_cnt_next;
            parallel  <= parallel_next;
        end
    end

    always_comb begin
        state_next    = state;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt;
        idle_cnt_next = idle_cnt;
        parallel_next = parallel;
        case (state)
            IDLE: begin
                if (Enable && receive) begin
                    state_next    = WAIT_START;
                    bit_cnt_next  = '0;
                    idle_cnt_next = '0;
                end
            end
            WAIT_START: begin
                if (Enable) begin
                    if (!serial) begin
                        shift_next   = shift_full[WIDTH-2:0];
                        bit_cnt_next = BIT_W'(1);
                        state_next   = SHIFT;
                    end else begin
                        idle_cnt_next = idle_cnt_inc;
                        if (idle_cnt_inc == IDLE_LIMIT) begin
                            state_next = TIMED_OUT;
                        end
                    end
                end
            end
            SHIFT: begin
                if (Enable) begin
                    shift_next   = shift_full[WIDTH-2:0];
                    bit_cnt_next = bit_cnt_inc;
                    if (bit_cnt_inc == FRAME_BITS) begin
                        parallel_next = shift_full;
                        state_next    = DONE;
                    end
                end
            end
            DONE:      state_next = IDLE;
            TIMED_OUT: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    assign complete = (state == DONE);
    assign timeout  = (state == TIMED_OUT);
    assign busy     = (state == WAIT_START) || (state == SHIFT) || (state == DONE);

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench for serial_to_parallel_rx: drives frames cycle by cycle and predicts
// strobe cycles and captured words from frame arithmetic (accept edge + idle + WIDTH + gaps).
module tb_serial_to_parallel_rx;

    localparam int W  = 48;
    localparam int TO = 64;

    logic         Clock;
    logic         Reset;
    logic         Enable;
    logic         receive;
    logic         serial;
    logic [W-1:0] parallel;
    logic         complete;
    logic         busy;
    logic         timeout;

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           comp_cyc[$];
    logic [W-1:0] comp_val[$];
    int           to_cyc[$];
    bit           busy_log[int];
    bit           overlap = 0;
    logic [W-1:0] last_frame = '0;

    serial_to_parallel_rx #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Enable   (Enable),
        .receive  (receive),
        .serial   (serial),
        .parallel (parallel),
        .complete (complete),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // One clock edge; outputs are logged 1 time unit later, labelled with the edge count.
    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
        busy_log[cyc] = busy;
        if (complete) begin
            comp_cyc.push_back(cyc);
            comp_val.push_back(parallel);
        end
        if (timeout) to_cyc.push_back(cyc);
        if (complete && timeout) overlap = 1'b1;
    endtask

    task automatic clear_log();
        comp_cyc.delete();
        comp_val.delete();
        to_cyc.delete();
    endtask

    task automatic idle_ticks(input int n);
        receive = 1'b0;
        Enable  = 1'b1;
        serial  = 1'b1;
        repeat (n) tick();
    endtask

    task automatic gap_ticks(input int n);
        Enable = 1'b0;
        repeat (n) begin
            serial = 1'($urandom);
            tick();
        end
        Enable = 1'b1;
    endtask

    // Accepts a request, sends idle_n ones, then n_bits of frame MSB-first.
    // exp_cyc: edge after which complete must be seen = accept + idle + WIDTH + disabled cycles.
    task automatic send_frame(input logic [W-1:0] frame, input int idle_n, input int n_bits,
                              input int gap_after, input int gap_len, input bit rand_gaps,
                              input bit hold_rx, input int rx_pulse_at,
                              output int acc, output int exp_cyc);
        int gaps;
        int ng;
        gaps    = 0;
        Enable  = 1'b1;
        receive = 1'b1;
        serial  = 1'b1;
        tick();
        acc     = cyc;
        receive = hold_rx;
        for (int i = 0; i < idle_n; i++) begin
            if (rand_gaps && $urandom_range(0, 3) == 0) begin
                ng = int'($urandom_range(1, 2));
                gap_ticks(ng);
                gaps += ng;
            end
            serial = 1'b1;
            tick();
        end
        for (int b = 0; b < n_bits; b++) begin
            if (b == gap_after) begin
                gap_ticks(gap_len);
                gaps += gap_len;
            end
            if (rand_gaps && $urandom_range(0, 3) == 0) begin
                ng = int'($urandom_range(1, 2));
                gap_ticks(ng);
                gaps += ng;
            end
            serial  = frame[W-1-b];
            receive = hold_rx | (b == rx_pulse_at);
            tick();
            receive = hold_rx;
        end
        exp_cyc = acc + idle_n + W + gaps;
    endtask

    // Shared post-frame checks are written inline in each test so each reports its own name.
    task automatic test_reset();
        Reset   = 1'b0;
        Enable  = 1'b1;
        receive = 1'b1;
        serial  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({parallel, complete, busy, timeout} !== '0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: got par=%h c=%b b=%b t=%b want all zero",
                         i, parallel, complete, busy, timeout);
            end
        end
        Reset   = 1'b1;
        receive = 1'b0;
        serial  = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_nominal();
        logic [W-1:0] f;
        int acc, e, got_c;
        f = 48'h3F0F_0F0F_0F01;
        clear_log();
        send_frame(f, 3, W, -1, 0, 1'b0, 1'b0, -1, acc, e);
        idle_ticks(3);
        got_c = (comp_cyc.size() > 0) ? comp_cyc[0] : -1;
        total++;
        if (comp_cyc.size() !== 1) begin
            bad++;
            $display("FAIL nominal_count: got %0d want 1", comp_cyc.size());
        end
        total++;
        if (got_c !== e) begin
            bad++;
            $display("FAIL nominal_cycle: got %0d want %0d", got_c, e);
        end
        total++;
        if (parallel !== f) begin
            bad++;
            $display("FAIL nominal_value: got %h want %h", parallel, f);
        end
        total++;
        if (busy_log[acc + 1] !== 1'b1 || busy_log[acc] !== 1'b1) begin
            bad++;
            $display("FAIL nominal_busy_rise: got %b want 1", busy_log[acc]);
        end
        total++;
        if (busy_log[e] !== 1'b1 || busy_log[e + 1] !== 1'b0) begin
            bad++;
            $display("FAIL nominal_busy_fall: got %b%b want 10", busy_log[e], busy_log[e + 1]);
        end
        last_frame = f;
    endtask

    task automatic test_timeout();
        int acc, e, got_t;
        clear_log();
        Enable  = 1'b1;
        receive = 1'b1;
        serial  = 1'b1;
        tick();
        acc     = cyc;
        receive = 1'b0;
        for (int i = 0; i < TO; i++) begin
            if (i == 10) gap_ticks(2);
            serial = 1'b1;
            tick();
        end
        e = acc + TO + 2;
        idle_ticks(3);
        got_t = (to_cyc.size() > 0) ? to_cyc[0] : -1;
        total++;
        if (to_cyc.size() !== 1 || got_t !== e) begin
            bad++;
            $display("FAIL timeout_strobe: got n=%0d cyc=%0d want n=1 cyc=%0d", to_cyc.size(), got_t, e);
        end
        total++;
        if (comp_cyc.size() !== 0) begin
            bad++;
            $display("FAIL timeout_no_complete: got %0d want 0", comp_cyc.size());
        end
        total++;
        if (parallel !== last_frame) begin
            bad++;
            $display("FAIL timeout_parallel_held: got %h want %h", parallel, last_frame);
        end
        total++;
        if (busy_log[e - 1] !== 1'b1 || busy_log[e] !== 1'b0) begin
            bad++;
            $display("FAIL timeout_busy: got %b%b want 10", busy_log[e - 1], busy_log[e]);
        end
    endtask

    task automatic test_start_boundary();
        logic [W-1:0] f;
        int acc, e, got_c;
        f = 48'h0123_4567_89AB;
        clear_log();
        send_frame(f, TO - 1, W, -1, 0, 1'b0, 1'b0, -1, acc, e);
        idle_ticks(3);
        got_c = (comp_cyc.size() > 0) ? comp_cyc[0] : -1;
        total++;
        if (to_cyc.size() !== 0) begin
            bad++;
            $display("FAIL boundary_no_timeout: got %0d want 0", to_cyc.size());
        end
        total++;
        if (comp_cyc.size() !== 1 || got_c !== e || parallel !== f) begin
            bad++;
            $display("FAIL boundary_frame: got n=%0d cyc=%0d par=%h want n=1 cyc=%0d par=%h",
                     comp_cyc.size(), got_c, parallel, e, f);
        end
        last_frame = f;
    endtask

    task automatic test_enable_gap();
        logic [W-1:0] f;
        int acc, e, got_c;
        f = 48'h3F0F_0F0F_0F01;
        clear_log();
        send_frame(f, 3, W, 20, 5, 1'b0, 1'b0, -1, acc, e);
        idle_ticks(3);
        got_c = (comp_cyc.size() > 0) ? comp_cyc[0] : -1;
        total++;
        if (comp_cyc.size() !== 1 || got_c !== acc + 3 + W + 5) begin
            bad++;
            $display("FAIL gap_cycle: got n=%0d cyc=%0d want n=1 cyc=%0d", comp_cyc.size(), got_c, acc + 3 + W + 5);
        end
        total++;
        if (parallel !== f) begin
            bad++;
            $display("FAIL gap_value: got %h want %h", parallel, f);
        end
        last_frame = f;
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] f;
        int acc, e, got_c;
        clear_log();
        send_frame(48'h3F0F_0F0F_0F01, 2, 20, -1, 0, 1'b0, 1'b0, -1, acc, e);
        Reset = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || parallel !== '0 || complete !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs: got b=%b par=%h c=%b want 0/0/0", busy, parallel, complete);
        end
        Reset = 1'b1;
        idle_ticks(W + 2);
        total++;
        if (comp_cyc.size() !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_discard: got n=%0d busy=%b want 0/0", comp_cyc.size(), busy);
        end
        f = 48'h0000_0000_0001;
        clear_log();
        send_frame(f, 1, W, -1, 0, 1'b0, 1'b0, -1, acc, e);
        idle_ticks(3);
        got_c = (comp_cyc.size() > 0) ? comp_cyc[0] : -1;
        total++;
        if (comp_cyc.size() !== 1 || got_c !== e || parallel !== f) begin
            bad++;
            $display("FAIL midreset_next_frame: got n=%0d cyc=%0d par=%h want n=1 cyc=%0d par=%h",
                     comp_cyc.size(), got_c, parallel, e, f);
        end
        last_frame = f;
    endtask

    task automatic test_receive_ignored();
        logic [W-1:0] f;
        int acc, e;
        f = 48'h5A5A_1234_F00D & 48'h7FFF_FFFF_FFFF;
        clear_log();
        send_frame(f, 2, W, -1, 0, 1'b0, 1'b0, 10, acc, e);
        idle_ticks(4);
        total++;
        if (comp_cyc.size() !== 1 || parallel !== f) begin
            bad++;
            $display("FAIL rx_ignored: got n=%0d par=%h want n=1 par=%h", comp_cyc.size(), parallel, f);
        end
        total++;
        if (busy_log[e + 2] !== 1'b0) begin
            bad++;
            $display("FAIL rx_ignored_rearm: got busy=%b want 0", busy_log[e + 2]);
        end
        last_frame = f;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] f1, f2;
        int acc1, e1, acc2, e2, c0, c1;
        f1 = {1'b0, 47'($urandom), 16'($urandom)} ;
        f2 = {1'b0, 47'({$urandom, $urandom})};
        f1[W-1] = 1'b0;
        clear_log();
        send_frame(f1, 2, W, -1, 0, 1'b0, 1'b1, -1, acc1, e1);
        receive = 1'b1;
        serial  = 1'b1;
        Enable  = 1'b1;
        tick();
        send_frame(f2, 4, W, -1, 0, 1'b0, 1'b1, -1, acc2, e2);
        idle_ticks(4);
        c0 = (comp_cyc.size() > 0) ? comp_cyc[0] : -1;
        c1 = (comp_cyc.size() > 1) ? comp_cyc[1] : -1;
        total++;
        if (comp_cyc.size() !== 2 || c0 !== e1 || c1 !== e2) begin
            bad++;
            $display("FAIL b2b_cycles: got n=%0d %0d,%0d want 2 %0d,%0d", comp_cyc.size(), c0, c1, e1, e2);
        end
        total++;
        if (comp_val.size() !== 2 || comp_val[0] !== f1 || comp_val[1] !== f2) begin
            bad++;
            $display("FAIL b2b_values: got n=%0d want %h,%h", comp_val.size(), f1, f2);
        end
        total++;
        if (busy_log[e1 + 1] !== 1'b0 || busy_log[e1 + 2] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_one_idle: got %b%b want 01", busy_log[e1 + 1], busy_log[e1 + 2]);
        end
        total++;
        if (busy_log[e2 + 2] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_release: got busy=%b want 0", busy_log[e2 + 2]);
        end
        last_frame = f2;
    endtask

    task automatic test_random_frames();
        logic [W-1:0] f;
        int acc, e, k, got_c;
        for (int r = 0; r < 8; r++) begin
            f = 48'({$urandom, $urandom});
            f[W-1] = 1'b0;
            k = int'($urandom_range(0, 12));
            clear_log();
            send_frame(f, k, W, -1, 0, 1'b1, 1'b0, -1, acc, e);
            idle_ticks(3);
            got_c = (comp_cyc.size() > 0) ? comp_cyc[0] : -1;
            total++;
            if (comp_cyc.size() !== 1 || got_c !== e || parallel !== f) begin
                bad++;
                $display("FAIL random[%0d]: got n=%0d cyc=%0d par=%h want n=1 cyc=%0d par=%h",
                         r, comp_cyc.size(), got_c, parallel, e, f);
            end
            last_frame = f;
        end
    endtask

    task automatic test_exclusive_strobes();
        total++;
        if (overlap !== 1'b0) begin
            bad++;
            $display("FAIL strobe_overlap: got %b want 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_start_boundary();
        test_enable_gap();
        test_reset_mid_frame();
        test_receive_ignored();
        test_back_to_back();
        test_random_frames();
        test_exclusive_strobes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
